// File: rtl/rvvi_replay_sched_if.sv
// ============================================================================
// rvvi_replay_sched_if : channel bundle between the RVVI scheduler and its
// neighbours (core source, active list, packetizer). Revision 1.0
// ============================================================================
`default_nettype none

interface rvvi_replay_sched_if #(
  parameter int WIDTH = 792,
  parameter int TW    = 16
);
  logic             NewValid;
  logic [WIDTH-1:0] NewData;
  logic             NewReady;
  logic             AlPush;
  logic             AlFull;
  logic             AlEmpty;
  logic             AckValid;
  logic             ReplayBusy;
  logic             ReplayValid;
  logic [WIDTH-1:0] ReplayData;
  logic             ReplayReady;
  logic             ReplayReq;
  logic             OutValid;
  logic [WIDTH-1:0] OutData;
  logic             OutReady;
  logic [TW-1:0]    TimeoutCycles;
  logic [7:0]       TimeoutCount;

  modport slave (
    input  NewValid, NewData, AlFull, AlEmpty, AckValid, ReplayBusy,
           ReplayValid, ReplayData, OutReady, TimeoutCycles,
    output NewReady, AlPush, ReplayReady, ReplayReq, OutValid, OutData,
           TimeoutCount
  );

  modport master (
    output NewValid, NewData, AlFull, AlEmpty, AckValid, ReplayBusy,
           ReplayValid, ReplayData, OutReady, TimeoutCycles,
    input  NewReady, AlPush, ReplayReady, ReplayReq, OutValid, OutData,
           TimeoutCount
  );
endinterface

`default_nettype wire

// File: rtl/rvvi_replay_sched.sv
// ============================================================================
// rvvi_replay_sched : arbitrates new vs. replayed RVVI records onto one
// registered output and requests replay on acknowledge timeout. Revision 1.0
// ============================================================================
`default_nettype none

module rvvi_replay_sched #(
  parameter int WIDTH = 792,
  parameter int TW    = 16
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  rvvi_replay_sched_if.slave bus
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_REQ    = 2'd1,
    ST_REPLAY = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [TW-1:0]    timer, timer_nxt;
  logic [7:0]       tcount, tcount_nxt;

  logic load;
  logic new_ready;
  logic replay_ready;
  logic new_take;
  logic replay_take;
  logic timer_clr;
  logic expire;

  assign load         = ~out_valid | bus.OutReady;
  assign new_take     = bus.NewValid & new_ready;
  assign replay_take  = bus.ReplayValid & replay_ready;
  assign timer_clr    = bus.AckValid | bus.AlEmpty | (state != ST_NORMAL)
                        | (bus.TimeoutCycles == '0);
  // Ack in the expiry cycle wins, so expiry is only seen when the timer is not clearing.
  assign expire       = ~timer_clr && (timer == bus.TimeoutCycles - TW'(1));

  always_comb begin
    state_nxt    = state;
    tcount_nxt   = tcount;
    new_ready    = 1'b0;
    replay_ready = 1'b0;
    timer_nxt    = timer_clr ? '0 : timer + TW'(1);
    case (state)
      ST_NORMAL: begin
        new_ready = ~bus.AlFull & load & ~bus.ReplayBusy;
        if (bus.ReplayBusy) begin
          state_nxt = ST_REPLAY;
        end else if (expire) begin
          state_nxt  = ST_REQ;
          tcount_nxt = (tcount == 8'hFF) ? tcount : tcount + 8'd1;
        end
      end
      ST_REQ: begin
        if (bus.ReplayBusy) begin
          state_nxt = ST_REPLAY;
        end else if (bus.AlEmpty) begin
          state_nxt = ST_NORMAL;
        end
      end
      ST_REPLAY: begin
        replay_ready = load;
        if (~bus.ReplayBusy & ~bus.ReplayValid) begin
          state_nxt = ST_NORMAL;
        end
      end
      default: state_nxt = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_NORMAL;
      timer  <= '0;
      tcount <= '0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      tcount <= tcount_nxt;
    end
  end

  // Single output register; data only moves when a source is actually taken.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= new_take | replay_take;
      if (new_take) begin
        out_data <= bus.NewData;
      end else if (replay_take) begin
        out_data <= bus.ReplayData;
      end
    end
  end

  assign bus.NewReady     = new_ready;
  assign bus.AlPush       = new_take;
  assign bus.ReplayReady  = replay_ready;
  assign bus.ReplayReq    = (state == ST_REQ);
  assign bus.OutValid     = out_valid;
  assign bus.OutData      = out_data;
  assign bus.TimeoutCount = tcount;

endmodule

`default_nettype wire

// File: tb/tb_rvvi_replay_sched.sv
// ============================================================================
// tb_rvvi_replay_sched : directed checks of streaming, backpressure, timeout,
// ack race, list-initiated replay and async reset. Revision 1.0
// ============================================================================
`default_nettype none

module tb_rvvi_replay_sched;
  localparam int W  = 792;
  localparam int TW = 16;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;

  rvvi_replay_sched_if #(.WIDTH(W), .TW(TW)) bus ();

  rvvi_replay_sched #(.WIDTH(W), .TW(TW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [W-1:0] rec(input int n);
    logic [W-1:0] r;
    r = '0;
    r[31:0]     = 32'hC0DE0000 + n;
    r[W-1 -: 32] = 32'hBEEF0000 + n;
    return r;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn            = 1'b0;
    bus.NewValid      = 1'b0;
    bus.NewData       = '0;
    bus.AlFull        = 1'b0;
    bus.AlEmpty       = 1'b1;
    bus.AckValid      = 1'b0;
    bus.ReplayBusy    = 1'b0;
    bus.ReplayValid   = 1'b0;
    bus.ReplayData    = '0;
    bus.OutReady      = 1'b1;
    bus.TimeoutCycles = '0;
    #3;
    chk("rst_outvalid", bus.OutValid, 0);
    chk("rst_outdata",  bus.OutData, 0);
    chk("rst_tcount",   bus.TimeoutCount, 0);
    chk("rst_req",      bus.ReplayReq, 0);
    chk("rst_newready", bus.NewReady, 1);
    chk("rst_rpready",  bus.ReplayReady, 0);
    cyc();
    resetn = 1'b1;

    // Stream of four records
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.NewValid = 1'b1;
      bus.NewData  = rec(i);
      settle();
      chk("stream_push", bus.AlPush, 1);
      if (i > 0) begin
        chk("stream_data", bus.OutData, rec(i - 1));
        chk("stream_valid", bus.OutValid, 1);
      end
    end
    cyc();
    bus.NewValid = 1'b0;
    settle();
    chk("stream_last", bus.OutData, rec(3));
    chk("stream_nopush", bus.AlPush, 0);

    // Backpressure holds the pending record
    cyc();
    bus.NewValid = 1'b1;
    bus.NewData  = rec(4);
    settle();
    chk("bp_push0", bus.AlPush, 1);
    for (int j = 0; j < 3; j++) begin
      cyc();
      bus.OutReady = 1'b0;
      bus.NewData  = rec(5);
      settle();
      chk("bp_hold", bus.OutData, rec(4));
      chk("bp_newready", bus.NewReady, 0);
      chk("bp_nopush", bus.AlPush, 0);
    end
    cyc();
    bus.OutReady = 1'b1;
    settle();
    chk("bp_release", bus.AlPush, 1);
    cyc();
    bus.NewValid = 1'b0;
    settle();
    chk("bp_next", bus.OutData, rec(5));

    // Timeout: AlEmpty drops in cycle 0, expiry at cycle 4, REQ in cycle 5
    cyc();
    bus.TimeoutCycles = 16'd5;
    settle();
    for (int k = 0; k < 5; k++) begin
      cyc();
      bus.AlEmpty = 1'b0;
      settle();
      chk("to_noreq", bus.ReplayReq, 0);
    end
    cyc();
    bus.NewValid = 1'b1;
    bus.NewData  = rec(9);
    settle();
    chk("to_req", bus.ReplayReq, 1);
    chk("to_count", bus.TimeoutCount, 1);
    chk("to_req_newready", bus.NewReady, 0);
    cyc();
    settle();
    chk("to_req_hold", bus.ReplayReq, 1);
    cyc();
    bus.ReplayBusy = 1'b1;
    settle();
    chk("to_req_busy", bus.ReplayReq, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.ReplayValid = 1'b1;
      bus.ReplayData  = rec(100 + i);
      settle();
      chk("rp_ready", bus.ReplayReady, 1);
      chk("rp_newready", bus.NewReady, 0);
      chk("rp_nopush", bus.AlPush, 0);
      chk("rp_noreq", bus.ReplayReq, 0);
      if (i > 0) chk("rp_data", bus.OutData, rec(100 + i - 1));
    end
    cyc();
    bus.ReplayValid = 1'b0;
    bus.ReplayBusy  = 1'b0;
    settle();
    chk("rp_last", bus.OutData, rec(102));
    chk("rp_still_newready", bus.NewReady, 0);
    cyc();
    bus.NewValid = 1'b0;
    bus.AlEmpty  = 1'b1;
    settle();
    chk("rp_exit_newready", bus.NewReady, 1);
    chk("rp_exit_valid", bus.OutValid, 0);
    chk("rp_exit_count", bus.TimeoutCount, 1);

    // Ack in the expiry cycle restarts the timer from zero
    for (int k = 0; k < 10; k++) begin
      cyc();
      bus.AlEmpty  = 1'b0;
      bus.AckValid = (k == 4);
      settle();
      chk("ack_noreq", bus.ReplayReq, 0);
    end
    cyc();
    bus.AckValid = 1'b0;
    settle();
    chk("ack_req", bus.ReplayReq, 1);
    chk("ack_count", bus.TimeoutCount, 2);
    cyc();
    bus.AlEmpty = 1'b1;
    settle();
    chk("ack_req_hold", bus.ReplayReq, 1);
    cyc();
    settle();
    chk("ack_req_exit", bus.ReplayReq, 0);

    // Active-list replay coincident with expiry takes priority
    for (int k = 0; k < 4; k++) begin
      cyc();
      bus.AlEmpty = 1'b0;
      settle();
      chk("al_noreq", bus.ReplayReq, 0);
    end
    cyc();
    bus.ReplayBusy = 1'b1;
    settle();
    chk("al_busy_newready", bus.NewReady, 0);
    cyc();
    bus.ReplayValid = 1'b1;
    bus.ReplayData  = rec(200);
    settle();
    chk("al_noreq_after", bus.ReplayReq, 0);
    chk("al_count", bus.TimeoutCount, 2);
    chk("al_replay_ready", bus.ReplayReady, 1);
    cyc();
    bus.ReplayValid = 1'b0;
    settle();
    chk("al_data", bus.OutData, rec(200));
    chk("al_valid", bus.OutValid, 1);

    // Asynchronous reset mid-replay
    #2;
    resetn = 1'b0;
    settle();
    chk("ar_valid", bus.OutValid, 0);
    chk("ar_data", bus.OutData, 0);
    chk("ar_count", bus.TimeoutCount, 0);
    chk("ar_rpready", bus.ReplayReady, 0);
    chk("ar_newready", bus.NewReady, 0);
    bus.ReplayBusy    = 1'b0;
    bus.TimeoutCycles = '0;
    settle();
    chk("ar_newready_idle", bus.NewReady, 1);
    cyc();
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      settle();
      chk("dis_noreq", bus.ReplayReq, 0);
    end
    chk("dis_count", bus.TimeoutCount, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
